// File: rtl/sys_timer_cmp.sv
// sys_timer_cmp: free-running system counter with a prescaler, atomic
// 32-bit software access over APB, NUM_CMP compare channels (one-shot or
// periodic auto-reload) and an overflow interrupt.
//
// APB handshake: zero wait state, pready is always 1. A transfer is the
// setup phase (psel=1, penable=0) followed by one access phase
// (psel=1, penable=1). Writes commit on the clock edge that ends the access
// phase. Read data and pslverr are driven combinationally during the access
// phase and are 0 at all other times.
module sys_timer_cmp #(
  parameter int CNT_W   = 64,
  parameter int PRE_W   = 16,
  parameter int NUM_CMP = 4
) (
  input  logic               sys_clk,
  input  logic               sys_resetn,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [7:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  output logic [CNT_W-1:0]   cnt,
  output logic [NUM_CMP:0]   irq
);

  // Width of the upper counter half seen through the *_HI registers.
  localparam int HW = CNT_W - 32;
  // Interrupt sources: one per channel plus overflow at the top bit.
  localparam int NI = NUM_CMP + 1;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic               en_q;
  logic [PRE_W-1:0]   prescale_q;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        cnt_wsh_q;
  logic [HW-1:0]      cnt_rsh_q;
  logic [NI-1:0]      status_q, status_d;
  logic [NI-1:0]      int_en_q;
  logic [NI-1:0]      irq_q;

  logic [CNT_W-1:0]   cmp_q     [NUM_CMP];
  logic [CNT_W-1:0]   cmp_d     [NUM_CMP];
  logic [31:0]        period_q  [NUM_CMP];
  logic [31:0]        cmp_wsh_q [NUM_CMP];
  logic [HW-1:0]      cmp_rsh_q [NUM_CMP];
  logic [NUM_CMP-1:0] cen_q;
  logic [NUM_CMP-1:0] periodic_q;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic               acc, wr, rd;
  logic               glb_sel, glb_ok, ch_ok, addr_ok;
  logic [2:0]         glb_idx;
  logic [3:0]         ch_idx;
  logic [1:0]         sub;
  logic [NUM_CMP-1:0] ch_sel;
  logic [1:0]         unused_paddr;

  assign unused_paddr = paddr[1:0];

  assign acc     = psel & penable;
  assign glb_sel = (paddr[7:5] == 3'b000);
  assign glb_idx = paddr[4:2];
  assign glb_ok  = glb_sel & (glb_idx <= 3'd5);
  // Channel blocks start at 0x20 and are 0x10 bytes apart.
  assign ch_idx  = paddr[7:4] - 4'd2;
  assign sub     = paddr[3:2];
  assign ch_ok   = (paddr[7:4] >= 4'd2) & (ch_idx < 4'(NUM_CMP));
  assign addr_ok = glb_ok | ch_ok;
  assign wr      = acc & pwrite & addr_ok;
  assign rd      = acc & ~pwrite & addr_ok;

  // One-hot channel select for the addressed compare block.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      ch_sel[i] = ch_ok & (ch_idx == 4'(i));
    end
  end

  logic wr_ctrl, wr_pre, wr_cnt_lo, wr_cnt_hi, wr_status, wr_int_en, rd_cnt_lo;
  assign wr_ctrl   = wr & glb_sel & (glb_idx == 3'd0);
  assign wr_pre    = wr & glb_sel & (glb_idx == 3'd1);
  assign wr_cnt_lo = wr & glb_sel & (glb_idx == 3'd2);
  assign wr_cnt_hi = wr & glb_sel & (glb_idx == 3'd3);
  assign wr_status = wr & glb_sel & (glb_idx == 3'd4);
  assign wr_int_en = wr & glb_sel & (glb_idx == 3'd5);
  assign rd_cnt_lo = rd & glb_sel & (glb_idx == 3'd2);

  logic [NUM_CMP-1:0] wr_cmp_lo, wr_cmp_hi, wr_period, wr_cmp_ctrl, rd_cmp_lo;

  // Per-channel register strobes.
  always_comb begin
    wr_cmp_lo   = '0;
    wr_cmp_hi   = '0;
    wr_period   = '0;
    wr_cmp_ctrl = '0;
    rd_cmp_lo   = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      wr_cmp_lo[i]   = wr & ch_sel[i] & (sub == 2'd0);
      wr_cmp_hi[i]   = wr & ch_sel[i] & (sub == 2'd1);
      wr_period[i]   = wr & ch_sel[i] & (sub == 2'd2);
      wr_cmp_ctrl[i] = wr & ch_sel[i] & (sub == 2'd3);
      rd_cmp_lo[i]   = rd & ch_sel[i] & (sub == 2'd0);
    end
  end

  // ---------------------------------------------------------------------
  // Tick, counter, events
  // ---------------------------------------------------------------------
  logic               cnt_clr, sw_cnt, tick, ovf_evt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [NUM_CMP-1:0] match;

  assign cnt_clr = wr_ctrl & pwdata[1];
  // Software load or clear owns the counter this cycle; the tick is dropped
  // and cannot raise a match or overflow.
  assign sw_cnt  = cnt_clr | wr_cnt_hi;
  assign tick    = en_q & (pre_q == prescale_q);
  assign cnt_inc = cnt_q + 1'b1;
  assign ovf_evt = tick & ~sw_cnt & (cnt_q == {CNT_W{1'b1}});

  // Next counter and prescaler values, with software access taking priority.
  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (cnt_clr) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (wr_cnt_hi) begin
      cnt_d = {pwdata[HW-1:0], cnt_wsh_q};
      pre_d = '0;
    end else if (en_q) begin
      if (tick) begin
        cnt_d = cnt_inc;
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Compare matches and the next compare values (software write beats reload).
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      match[i] = tick & ~sw_cnt & cen_q[i] & (cnt_inc == cmp_q[i]);
      cmp_d[i] = cmp_q[i];
      if (wr_cmp_hi[i]) begin
        cmp_d[i] = {pwdata[HW-1:0], cmp_wsh_q[i]};
      end else if (match[i] & periodic_q[i]) begin
        cmp_d[i] = cmp_q[i] + {{HW{1'b0}}, period_q[i]};
      end
    end
  end

  // Status: write-1-to-clear, but a same-cycle set event wins.
  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      status_d = status_d & ~pwdata[NI-1:0];
    end
    status_d = status_d | {ovf_evt, match};
  end

  // Global control registers and the counter access shadows.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      en_q       <= 1'b0;
      prescale_q <= '0;
      int_en_q   <= '0;
      cnt_wsh_q  <= '0;
      cnt_rsh_q  <= '0;
    end else begin
      if (wr_ctrl)   en_q       <= pwdata[0];
      if (wr_pre)    prescale_q <= pwdata[PRE_W-1:0];
      if (wr_int_en) int_en_q   <= pwdata[NI-1:0];
      if (wr_cnt_lo) cnt_wsh_q  <= pwdata;
      if (rd_cnt_lo) cnt_rsh_q  <= cnt_q[CNT_W-1:32];
    end
  end

  // Counter, prescaler, status and the registered interrupt lines.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cnt_q    <= '0;
      pre_q    <= '0;
      status_q <= '0;
      irq_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      status_q <= status_d;
      irq_q    <= status_q & int_en_q;
    end
  end

  // Compare channel registers and their access shadows.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      cen_q      <= '0;
      periodic_q <= '0;
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp_q[i]     <= {CNT_W{1'b1}};
        period_q[i]  <= '0;
        cmp_wsh_q[i] <= '0;
        cmp_rsh_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp_q[i] <= cmp_d[i];
        if (wr_period[i]) period_q[i]  <= pwdata;
        if (wr_cmp_lo[i]) cmp_wsh_q[i] <= pwdata;
        if (rd_cmp_lo[i]) cmp_rsh_q[i] <= cmp_q[i][CNT_W-1:32];
        if (wr_cmp_ctrl[i]) begin
          cen_q[i]      <= pwdata[0];
          periodic_q[i] <= pwdata[1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------
  logic [31:0] rdata;

  // Read mux over the global block and the selected channel block.
  always_comb begin
    rdata = '0;
    if (glb_sel) begin
      case (glb_idx)
        3'd0:    rdata[0]         = en_q;
        3'd1:    rdata[PRE_W-1:0] = prescale_q;
        3'd2:    rdata            = cnt_q[31:0];
        3'd3:    rdata[HW-1:0]    = cnt_rsh_q;
        3'd4:    rdata[NI-1:0]    = status_q;
        3'd5:    rdata[NI-1:0]    = int_en_q;
        default: rdata            = '0;
      endcase
    end
    for (int i = 0; i < NUM_CMP; i++) begin
      if (ch_sel[i]) begin
        case (sub)
          2'd0:    rdata         = cmp_q[i][31:0];
          2'd1:    rdata[HW-1:0] = cmp_rsh_q[i];
          2'd2:    rdata         = period_q[i];
          default: rdata[1:0]    = {periodic_q[i], cen_q[i]};
        endcase
      end
    end
  end

  assign prdata  = rd ? rdata : 32'd0;
  assign pslverr = acc & ~addr_ok;
  assign pready  = 1'b1;
  assign cnt     = cnt_q;
  assign irq     = irq_q;

endmodule
